// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed hex display driver for a common-anode seven-segment bank.
// One digit is driven at a time from a shadow copy of the packed hex value.
// The shadow only changes at a frame boundary (scan wrap to digit 0), so a
// frame never shows a mix of old and new data. Loads that arrive mid-frame
// are parked in a pending register; the last one before the boundary wins.
//
// Optional feature (compile-time macro GHOST_BLANK_EN):
//   When defined, the anodes are held off for the first GHOST_CYCLES clocks
//   of every digit slot while seg/dp already carry the new digit.
//   When undefined, GHOST_CYCLES has no effect.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   value       in   packed hex nibbles, digit i = value[4i+3:4i]
//   dp_in       in   decimal-point request per digit, 1 = lit
//   load        in   capture value/dp_in this cycle
//   blank_lz    in   leading-zero blanking enable, sampled live
//   seg         out  segments {a,b,c,d,e,f,g}, active-low
//   dp          out  decimal point, active-low
//   an          out  digit enables, active-low, one-hot-low when active
//   frame_tick  out  one-clock pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,      // at least 2
    parameter int REFRESH_DIV  = 50000,  // clocks per digit slot, at least 4
    parameter int GHOST_CYCLES = 2       // less than REFRESH_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] GHOST_LIM  = PW'(GHOST_CYCLES);

`ifdef GHOST_BLANK_EN
    localparam bit GHOST_EN = 1'b1;
`else
    localparam bit GHOST_EN = 1'b0;
`endif

    // Scan position
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;

    // Pending (mid-frame load) and shadow (displayed) data
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

    // Registered outputs
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;

    // Combinational helpers
    logic                  slot_end;
    logic                  wrap;
    logic [3:0]            cur_nib;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  lz_run;
    logic                  blanked;
    logic                  ghost_win;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h0C;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            4'hF: s = 7'h38;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------------
    // Scan counters and data capture
    // ---------------------------------------------------------------------
    always_comb begin
        slot_end     = (presc_q == PRESC_LAST);
        wrap         = slot_end && (idx_q == IDX_LAST);

        presc_d      = slot_end ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end

        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;

        if (wrap) begin
            // A load on the boundary cycle beats anything already pending.
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end

        frame_tick_d = wrap;
    end

    // ---------------------------------------------------------------------
    // Output image of the current digit
    // ---------------------------------------------------------------------
    always_comb begin
        // upper_zero[i] = nibbles i..NUM_DIGITS-1 of the shadow are all zero
        upper_zero = '0;
        lz_run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run        = lz_run & (shadow_val_q[4*i +: 4] == 4'h0);
            upper_zero[i] = lz_run;
        end

        cur_nib   = shadow_val_q[{idx_q, 2'b00} +: 4];
        // Digit 0 is never blanked so a zero value still shows one "0".
        blanked   = blank_lz && (idx_q != '0) && upper_zero[idx_q];
        ghost_win = (presc_q < GHOST_LIM);

        seg_d = blanked ? 7'h7F : hex_to_seg(cur_nib);
        dp_d  = ~shadow_dp_q[idx_q];
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        if (GHOST_EN && ghost_win) begin
            an_d = '1;
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Drives seven_seg_scan (4 digits, 4 clocks per slot, 1 ghost cycle) with
// directed scenarios and random loads. A behavioural model derives the scan
// position from a cycle count since reset and tracks displayed/pending data;
// a compare process checks every output on every negative clock edge.
// Directed checks pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int GC = 1;

`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------------
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] value    = '0;
    logic [3:0]  dp_in    = '0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b1;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .GHOST_CYCLES(GC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value     (value),
        .dp_in     (dp_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_tick(frame_tick)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    logic [6:0] dec_tab [0:15] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                   7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int          t      = 0;   // clocks since reset release
    int          m_idx  = 0;
    int          m_ph   = 0;
    logic [15:0] sh_val = '0;
    logic [3:0]  sh_dp  = '0;
    logic [15:0] pe_val = '0;
    logic [3:0]  pe_dp  = '0;
    bit          pe_v   = 1'b0;
    logic [6:0]  e_seg  = 7'h7F;
    logic        e_dp   = 1'b1;
    logic [3:0]  e_an   = 4'hF;
    logic        e_ft   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; sh_val = '0; sh_dp = '0; pe_val = '0; pe_dp = '0; pe_v = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
        end else begin
            m_idx = (t / RD) % N;
            m_ph  = t % RD;
            if (m_idx > 0 && blank_lz && (sh_val >> (4 * m_idx)) == 16'h0)
                e_seg = 7'h7F;
            else
                e_seg = dec_tab[sh_val[4*m_idx +: 4]];
            e_dp = ~sh_dp[m_idx];
            e_an = 4'hF;
            if (!(GHOST && m_ph < GC)) e_an[m_idx] = 1'b0;
            e_ft = ((t % (RD * N)) == RD * N - 1);
            if (e_ft) begin
                if (load) begin
                    sh_val = value; sh_dp = dp_in;
                end else if (pe_v) begin
                    sh_val = pe_val; sh_dp = pe_dp;
                end
                pe_v = 1'b0;
            end else if (load) begin
                pe_val = value; pe_dp = dp_in; pe_v = 1'b1;
            end
            t++;
        end
    end

    // ---------------------------------------------------------------------
    // Compare process
    // ---------------------------------------------------------------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", {9'h0, seg}, {9'h0, e_seg});
            check("model_dp", {15'h0, dp}, {15'h0, e_dp});
            check("model_an", {12'h0, an}, {12'h0, e_an});
            check("model_ft", {15'h0, frame_tick}, {15'h0, e_ft});
        end
    end

    // ---------------------------------------------------------------------
    // Driver helpers; off = negedges since the last observed frame_tick
    // ---------------------------------------------------------------------
    int off = 0;

    task automatic adv_to(input int m);
        while (off < m) begin
            @(negedge clk);
            off++;
        end
    endtask

    task automatic wait_ft();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 64);
        check("frame_sync", {15'h0, frame_tick}, 16'h1);
        off = 0;
    endtask

    // Sample digit k in its slot (past any ghost window).
    task automatic dig(input string nm, input int k, input logic [6:0] s, input logic d);
        logic [3:0] a;
        a = 4'hF;
        a[k] = 1'b0;
        adv_to((k + 1) * RD);
        check({nm, "_seg"}, {9'h0, seg}, {9'h0, s});
        check({nm, "_an"}, {12'h0, an}, {12'h0, a});
        check({nm, "_dp"}, {15'h0, dp}, {15'h0, d});
    endtask

    // After digit 3 the next frame must begin exactly one slot later.
    task automatic next_frame(input string nm);
        check(nm, {15'h0, frame_tick}, 16'h1);
        off = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] v;

        repeat (3) @(negedge clk);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_ft", {15'h0, frame_tick}, 16'h0000);

        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        check("first_seg", {9'h0, seg}, 16'h0001);
        check("first_an", {12'h0, an}, GHOST ? 16'h000F : 16'h000E);

        // Idle frame: zero shown as a single "0"
        wait_ft();
        dig("idle_d0", 0, 7'h01, 1'b1);
        dig("idle_d1", 1, 7'h7F, 1'b1);
        dig("idle_d2", 2, 7'h7F, 1'b1);
        dig("idle_d3", 3, 7'h7F, 1'b1);
        check("idle_ft_pre", {15'h0, frame_tick}, 16'h1);
        next_frame("idle_period");

        // Mid-frame load is held until the wrap
        adv_to(5);
        value = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
        adv_to(6);
        load = 1'b0;
        dig("hold_d3", 3, 7'h7F, 1'b1);
        next_frame("hold_period");
        dig("ld_d0", 0, 7'h38, 1'b1);
        dig("ld_d1", 1, 7'h06, 1'b1);
        dig("ld_d2", 2, 7'h08, 1'b0);
        dig("ld_d3", 3, 7'h4F, 1'b1);
        next_frame("ld_period");

        // Load on the boundary cycle beats a pending value
        adv_to(3);
        value = 16'h5555; dp_in = 4'b1111; load = 1'b1;
        adv_to(4);
        load = 1'b0;
        adv_to(15);
        value = 16'h00C0; dp_in = 4'b0000; load = 1'b1;
        adv_to(16);
        load = 1'b0;
        next_frame("bnd_period");
        dig("bnd_d0", 0, 7'h01, 1'b1);
        dig("bnd_d1", 1, 7'h31, 1'b1);
        dig("bnd_d2", 2, 7'h7F, 1'b1);
        dig("bnd_d3", 3, 7'h7F, 1'b1);
        next_frame("bnd_period2");

        // Two loads in one frame: only the last is ever shown
        adv_to(2);
        value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
        adv_to(3);
        load = 1'b0;
        adv_to(9);
        value = 16'h2222; load = 1'b1;
        adv_to(10);
        load = 1'b0;
        adv_to(16);
        next_frame("two_period");
        dig("two_d0", 0, 7'h12, 1'b1);
        dig("two_d1", 1, 7'h12, 1'b1);
        dig("two_d2", 2, 7'h12, 1'b1);
        dig("two_d3", 3, 7'h12, 1'b1);
        next_frame("two_period2");
        dig("two_next_d0", 0, 7'h12, 1'b1);

        // Random loads, dp and blanking toggles
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            v = $urandom;
            v = v >> (4 * $urandom_range(0, 4));
            value = v[15:0];
            dp_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        load = 1'b0;
        blank_lz = 1'b1;

        // Asynchronous reset at digit 2, prescaler 2
        wait_ft();
        adv_to(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg", {9'h0, seg}, 16'h007F);
        check("async_an", {12'h0, an}, 16'h000F);
        check("async_dp", {15'h0, dp}, 16'h0001);
        check("async_ft", {15'h0, frame_tick}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_seg", {9'h0, seg}, 16'h0001);
        check("rel_an", {12'h0, an}, GHOST ? 16'h000F : 16'h000E);
        check("rel_dp", {15'h0, dp}, 16'h0001);
        off = 1;
        dig("rel_d1", 1, 7'h7F, 1'b1);
        dig("rel_d3", 3, 7'h7F, 1'b1);
        next_frame("rel_period");

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
